sc_stream_collector: RTL and testbench
======================================

SC_STREAM_COLLECTOR -- requirements
Module: sc_stream_collector

Interface
REQ-001 SHALL have parameter BATCH_SIZE, default 4: M, rows of the result matrix.
REQ-002 SHALL have parameter OUTPUT_FEATURES, default 4: O, columns of the result matrix.
REQ-003 SHALL have parameter STREAM_LENGTH, default 256: samples per bitstream; power of 2, at least 2.
REQ-004 SHALL have derived parameter COUNT_WIDTH = clogb2(STREAM_LENGTH)+1, so a count of STREAM_LENGTH is representable.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: begin a new collection; honoured only in IDLE.
REQ-008 SHALL have port inputStreams, input, BATCH_SIZE*OUTPUT_FEATURES: one stochastic bit per result element; bit (i*OUTPUT_FEATURES)+j is element (i,j).
REQ-009 SHALL have port inputWriteEn, input, 1: inputStreams holds a valid sample this cycle.
REQ-010 SHALL have port outputCounts, output, BATCH_SIZE*OUTPUT_FEATURES*COUNT_WIDTH: the binary count for element k at [k*COUNT_WIDTH +: COUNT_WIDTH].
REQ-011 SHALL have port outputValid, output, 1: outputCounts is complete and stable.
REQ-012 SHALL have port outputReady, input, 1: the consumer accepts outputCounts.
REQ-013 SHALL have port busy, output, 1: high in ACCUM.

Function
REQ-014 SHALL implement an FSM with states IDLE, ACCUM, DONE.
REQ-015 IDLE with start=1 SHALL clear all element counters and the sample counter, then go to ACCUM; inputStreams is not sampled on the start cycle.
REQ-016 In ACCUM, each cycle with inputWriteEn=1 SHALL add bit k of inputStreams to counter k for every k, and increment the sample counter.
REQ-017 In ACCUM, cycles with inputWriteEn=0 SHALL leave all counters unchanged; gaps are unlimited.
REQ-018 When the STREAM_LENGTH-th sample is accepted, the FSM SHALL move to DONE, with outputValid=1 from the next cycle.
REQ-019 In DONE, outputCounts and outputValid SHALL hold stable until a cycle with outputValid=1 and outputReady=1.
REQ-020 On that handshake cycle the FSM SHALL return to IDLE, with outputValid=0 the next cycle; outputCounts retains its last value in IDLE.
REQ-021 start SHALL be ignored in ACCUM and DONE, including the handshake cycle.
REQ-022 inputWriteEn SHALL be ignored in IDLE and DONE.
REQ-023 Counters SHALL never overflow; the maximum value is STREAM_LENGTH, reached when all samples are 1.
REQ-024 busy SHALL be 1 exactly while the state is ACCUM.
REQ-025 outputValid SHALL be 1 exactly while the state is DONE.
REQ-026 Minimum start-to-outputValid latency SHALL be STREAM_LENGTH+1 cycles: start at cycle 0, samples on cycles 1..L, valid at cycle L+1.

Reset
REQ-027 rst=1 SHALL, on the next edge, force IDLE and clear all counters, outputCounts, outputValid and busy to 0, regardless of state.
REQ-028 rst SHALL take priority over start, inputWriteEn and outputReady in the same cycle.
REQ-029 After rst deasserts, the block SHALL wait in IDLE for start; partial results from an interrupted collection are discarded.

Verification (parameters M=2, O=2, L=8, COUNT_WIDTH=4)
REQ-030 All ones: start; then inputStreams=4'b1111 with inputWriteEn=1 for 8 cycles -> outputValid rises 9 cycles after start; every count = 8.
REQ-031 Mixed density: 8 samples with bit0 alternating 1/0, bit1=1, bit2=0, bit3 set on the first 2 samples only -> counts {e0=4, e1=8, e2=0, e3=2}.
REQ-032 Write gaps: 8 valid samples of all ones spread over 12 cycles, with inputWriteEn low on 4 cycles carrying inputStreams=1111 -> all counts = 8; outputValid one cycle after the 8th valid sample.
REQ-033 Backpressure: outputReady held 0 for 5 cycles in DONE, with start pulsed -> outputValid and outputCounts stable and start ignored; ready=1 gives one handshake, then IDLE.
REQ-034 Reset mid-ACCUM: rst after 3 samples -> next cycle busy=0, outputValid=0, outputCounts=0; a new start with 8 samples counts only the new samples.

Source files
------------

// File: rtl/sc_stream_collector.sv
`default_nettype none
// ============================================================================
//  Module      : sc_stream_collector
//  Description : Collects a batch of stochastic bitstreams into binary counts.
//                Each of the BATCH_SIZE x OUTPUT_FEATURES result elements gets
//                one bit per accepted sample. The number of ones is counted
//                over STREAM_LENGTH accepted samples, and then the counts are
//                presented with a valid/ready handshake.
//
//  Ports
//    clk           : single rising-edge clock
//    rst           : synchronous active-high reset
//    start         : begin a new collection (honoured only in IDLE)
//    inputStreams  : one stochastic bit per element; bit i*O+j is element (i,j)
//    inputWriteEn  : inputStreams carries a valid sample this cycle
//    outputCounts  : count of element k at [k*COUNT_WIDTH +: COUNT_WIDTH]
//    outputValid   : outputCounts is complete and stable (state DONE)
//    outputReady   : consumer accepts outputCounts
//    busy          : collection in progress (state ACCUM)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_stream_collector #(
    parameter  int BATCH_SIZE      = 4,
    parameter  int OUTPUT_FEATURES = 4,
    parameter  int STREAM_LENGTH   = 256,
    // One extra bit so a full count of STREAM_LENGTH fits.
    localparam int COUNT_WIDTH     = $clog2(STREAM_LENGTH) + 1
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               start,
    input  logic [BATCH_SIZE*OUTPUT_FEATURES-1:0]              inputStreams,
    input  logic                                               inputWriteEn,
    output logic [BATCH_SIZE*OUTPUT_FEATURES*COUNT_WIDTH-1:0]  outputCounts,
    output logic                                               outputValid,
    input  logic                                               outputReady,
    output logic                                               busy
);

    localparam int                   c_NUM_ELEM = BATCH_SIZE * OUTPUT_FEATURES;
    localparam logic [COUNT_WIDTH-1:0] c_LAST_SAMPLE = COUNT_WIDTH'(STREAM_LENGTH - 1);
    localparam logic [COUNT_WIDTH-1:0] c_ONE         = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                                  r_state;
    // Packed so that element k lands directly at [k*COUNT_WIDTH +: COUNT_WIDTH].
    logic [c_NUM_ELEM-1:0][COUNT_WIDTH-1:0]  r_counts;
    logic [COUNT_WIDTH-1:0]                  r_samples;
    logic                                    r_valid;
    logic                                    r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_counts  <= '0;
            r_samples <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // The start cycle only clears; its inputStreams is not a sample.
                    if (start) begin
                        r_counts  <= '0;
                        r_samples <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_ACCUM;
                    end
                end

                S_ACCUM: begin
                    if (inputWriteEn) begin
                        for (int k = 0; k < c_NUM_ELEM; k++) begin
                            r_counts[k] <= r_counts[k] + COUNT_WIDTH'(inputStreams[k]);
                        end
                        r_samples <= r_samples + c_ONE;
                        // r_samples still holds the pre-increment value, so this
                        // is the STREAM_LENGTH-th accepted sample.
                        if (r_samples == c_LAST_SAMPLE) begin
                            r_busy  <= 1'b0;
                            r_valid <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    // Counts stay frozen here; they also persist through IDLE
                    // until the next start clears them.
                    if (outputReady) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign outputCounts = r_counts;
    assign outputValid  = r_valid;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sc_stream_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sc_stream_collector
//  Description : Self-checking bench for sc_stream_collector with M=2, O=2,
//                L=8. A behavioural model (sample tally per element plus
//                collecting / result-pending flags) is compared against the DUT
//                on every falling edge. Directed scenarios add hand-computed
//                literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_stream_collector;

    localparam int M  = 2;
    localparam int O  = 2;
    localparam int L  = 8;
    localparam int CW = 4;
    localparam int N  = M * O;

    logic              clk;
    logic              rst;
    logic              start;
    logic [N-1:0]      inputStreams;
    logic              inputWriteEn;
    logic [N*CW-1:0]   outputCounts;
    logic              outputValid;
    logic              outputReady;
    logic              busy;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    sc_stream_collector #(
        .BATCH_SIZE      (M),
        .OUTPUT_FEATURES (O),
        .STREAM_LENGTH   (L)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .inputStreams (inputStreams),
        .inputWriteEn (inputWriteEn),
        .outputCounts (outputCounts),
        .outputValid  (outputValid),
        .outputReady  (outputReady),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cnt [N];
    int m_n;
    bit m_collecting;
    bit m_result;

    always @(posedge clk) begin
        if (rst) begin
            m_collecting <= 1'b0;
            m_result     <= 1'b0;
            m_n          <= 0;
            for (int k = 0; k < N; k++) m_cnt[k] <= 0;
        end else if (m_result) begin
            if (outputReady) m_result <= 1'b0;
        end else if (m_collecting) begin
            if (inputWriteEn) begin
                for (int k = 0; k < N; k++) m_cnt[k] <= m_cnt[k] + (inputStreams[k] ? 1 : 0);
                m_n <= m_n + 1;
                if (m_n + 1 == L) begin
                    m_collecting <= 1'b0;
                    m_result     <= 1'b1;
                end
            end
        end else if (start) begin
            m_collecting <= 1'b1;
            m_n          <= 0;
            for (int k = 0; k < N; k++) m_cnt[k] <= 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [N*CW-1:0] exp_counts;
            exp_counts = '0;
            for (int k = 0; k < N; k++) exp_counts[k*CW +: CW] = CW'(m_cnt[k]);
            chk("model_flags", {62'd0, busy, outputValid}, {62'd0, m_collecting, m_result});
            chk("model_counts", 64'(outputCounts), 64'(exp_counts));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] v, input logic en);
        inputStreams = v;
        inputWriteEn = en;
        step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic handshake();
        outputReady = 1'b1;
        step();
        outputReady = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int first_valid;
        logic [N-1:0] v;

        rst = 1'b1; start = 1'b0; inputStreams = '0; inputWriteEn = 1'b0; outputReady = 1'b0;
        step(); step();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_valid", 64'(outputValid), 64'd0);
        chk("reset_counts", 64'(outputCounts), 64'd0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Write enables in IDLE are ignored.
        send(4'b1111, 1'b1); send(4'b1111, 1'b1);
        chk("idle_we_ignored", 64'(outputCounts), 64'd0);

        // All ones, latency from the start cycle.
        lat = 0; first_valid = -1;
        start = 1'b1; inputStreams = 4'b1111; inputWriteEn = 1'b0;
        step(); lat++; start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        for (int s = 0; s < L; s++) begin
            send(4'b1111, 1'b1); lat++;
            if (outputValid && first_valid < 0) first_valid = lat;
        end
        inputWriteEn = 1'b0;
        for (int w = 0; w < 20 && first_valid < 0; w++) begin
            step(); lat++;
            if (outputValid) first_valid = lat;
        end
        chk("all_ones_latency", 64'(first_valid), 64'd9);
        chk("all_ones_counts", 64'(outputCounts), 64'h8888);
        chk("all_ones_busy", 64'(busy), 64'd0);
        handshake();
        chk("handshake_valid", 64'(outputValid), 64'd0);
        chk("idle_retains", 64'(outputCounts), 64'h8888);

        // Mixed density.
        do_start();
        for (int s = 0; s < L; s++) begin
            v[0] = (s % 2 == 0);
            v[1] = 1'b1;
            v[2] = 1'b0;
            v[3] = (s < 2);
            send(v, 1'b1);
        end
        inputWriteEn = 1'b0;
        chk("mixed_valid", 64'(outputValid), 64'd1);
        chk("mixed_counts", 64'(outputCounts), 64'h2084);
        handshake();

        // Write gaps: 12 cycles, enable low on 4 of them with all-ones data.
        do_start();
        begin
            int accepted = 0;
            for (int c = 0; c < 12; c++) begin
                logic en;
                en = !(c == 1 || c == 4 || c == 6 || c == 9);
                send(4'b1111, en);
                if (en) accepted++;
                if (accepted < L) chk("gap_not_valid_yet", 64'(outputValid), 64'd0);
            end
            chk("gap_accepted", 64'(accepted), 64'd8);
        end
        inputWriteEn = 1'b0;
        chk("gap_valid", 64'(outputValid), 64'd1);
        chk("gap_counts", 64'(outputCounts), 64'h8888);

        // Backpressure with start pulsed while DONE.
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            outputReady = 1'b0;
            send(4'b0000, 1'b1);
            chk("bp_valid", 64'(outputValid), 64'd1);
            chk("bp_counts", 64'(outputCounts), 64'h8888);
        end
        inputWriteEn = 1'b0;
        start = 1'b1;           // also ignored on the handshake cycle
        handshake();
        start = 1'b0;
        chk("bp_release_valid", 64'(outputValid), 64'd0);
        chk("bp_start_ignored", 64'(busy), 64'd0);
        step();
        chk("bp_still_idle", 64'(busy), 64'd0);

        // Reset mid-ACCUM.
        do_start();
        send(4'b1111, 1'b1); send(4'b1111, 1'b1); send(4'b1111, 1'b1);
        rst = 1'b1; start = 1'b1; inputWriteEn = 1'b1; outputReady = 1'b1;
        step();
        rst = 1'b0; start = 1'b0; inputWriteEn = 1'b0; outputReady = 1'b0;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_valid", 64'(outputValid), 64'd0);
        chk("rst_mid_counts", 64'(outputCounts), 64'd0);
        step(); step();
        chk("rst_waits_idle", 64'(busy), 64'd0);
        do_start();
        for (int s = 0; s < L; s++) send(4'b0101, 1'b1);
        inputWriteEn = 1'b0;
        chk("rst_new_valid", 64'(outputValid), 64'd1);
        chk("rst_new_counts", 64'(outputCounts), 64'h0808);
        handshake();
        step();

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
